// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared MEM-stage state encoding, control-field indices, defaults
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam int M_BRANCH   = 0;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 2;

  localparam int unsigned DMEM_TIMEOUT_DEF = 15;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register; i_bubble zeroes the writeback controls
// Revision   : 1.0
// ---------------------------------------------------------------------------
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bubble,
  input  logic [1:0]  i_wb,
  input  logic [31:0] i_mem_data,
  input  logic [31:0] i_alu,
  input  logic [4:0]  i_dst,
  output logic [1:0]  o_wb,
  output logic [31:0] o_mem_data,
  output logic [31:0] o_alu,
  output logic [4:0]  o_dst
);

  logic [1:0]  r_wb;
  logic [31:0] r_mem_data;
  logic [31:0] r_alu;
  logic [4:0]  r_dst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb       <= 2'b00;
      r_mem_data <= 32'd0;
      r_alu      <= 32'd0;
      r_dst      <= 5'd0;
    end else begin
      r_wb       <= i_bubble ? 2'b00 : i_wb;
      r_mem_data <= i_mem_data;
      r_alu      <= i_alu;
      r_dst      <= i_dst;
    end
  end

  assign o_wb       = r_wb;
  assign o_mem_data = r_mem_data;
  assign o_alu      = r_alu;
  assign o_dst      = r_dst;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage : pipeline MEM stage with data-memory handshake, timeout fault,
//             branch redirect and MEM/WB register.
//             Optional MEM_ALIGN_CHECK_EN: misaligned accesses fault, no request.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data2,
  input  logic [4:0]  write_dst,
  input  logic [1:0]  wb,
  input  logic        branch,
  input  logic        zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [29:0] branch_dst,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        pc_src,
  output logic [29:0] branch_target,
  output logic        stall,
  output logic        mem_fault,
  output logic [1:0]  wb_out,
  output logic [31:0] mem_data,
  output logic [31:0] alu_out,
  output logic [4:0]  dst_out
);

  localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);

  mem_state_t       r_state;
  mem_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_mem_fault;

  logic [2:0]  w_mctl;
  logic        w_access;
  logic        w_rw_both;
  logic        w_is_read;
  logic        w_misalign;
  logic        w_timeout_hit;
  logic        w_req;
  logic        w_stall;
  logic        w_fault;
  logic [1:0]  w_wb_in;
  logic [31:0] w_mem_data_in;

  assign w_mctl    = {mem_write, mem_read, branch};
  assign w_access  = w_mctl[M_MEMREAD] | w_mctl[M_MEMWRITE];
  assign w_rw_both = w_mctl[M_MEMREAD] & w_mctl[M_MEMWRITE];
  assign w_is_read = w_mctl[M_MEMREAD] & ~w_mctl[M_MEMWRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_access & (alu_result[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_timeout_hit = (r_cnt == CNT_W'(DMEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mem_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_fault <= w_fault;
    end
  end

  // A fault releases the stall so the offending instruction leaves EX/MEM as a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_misalign) begin
          w_fault = 1'b1;
        end else if (w_access) begin
          w_req = 1'b1;
          if (!dmem_ready) begin
            w_stall     = 1'b1;
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          w_req       = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_timeout_hit) begin
          w_fault     = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_req     = 1'b1;
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Gating with rst_n drops the request the instant reset is asserted.
  assign dmem_req   = rst_n & w_req;
  assign dmem_we    = dmem_req & w_mctl[M_MEMWRITE];
  assign dmem_addr  = alu_result[31:2];
  assign dmem_wdata = read_data2;
  assign stall      = rst_n & w_stall;
  assign mem_fault  = r_mem_fault;

  assign pc_src        = w_mctl[M_BRANCH] & zero & ~stall;
  assign branch_target = branch_dst;

  assign w_wb_in[WB_REGWRITE] = wb[WB_REGWRITE] & ~w_rw_both;
  assign w_wb_in[WB_MEMTOREG] = wb[WB_MEMTOREG] & ~w_rw_both;
  assign w_mem_data_in        = w_is_read ? dmem_rdata : 32'd0;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bubble   (w_stall | w_fault),
    .i_wb       (w_wb_in),
    .i_mem_data (w_mem_data_in),
    .i_alu      (alu_result),
    .i_dst      (write_dst),
    .o_wb       (wb_out),
    .o_mem_data (mem_data),
    .o_alu      (alu_out),
    .o_dst      (dst_out)
  );

endmodule
`default_nettype wire
